// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: FSM state encoding,
// requester/owner codes and the default access latency.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  localparam int MEM_LAT_DEFAULT = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between CPU (idx 0) and DMA (idx 1).
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise the CPU always wins ties.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic [1:0] excl,
  input  logic       rr_ptr,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic [1:0] elig;

  assign elig        = req & ~excl;
  assign grant_valid = |elig;

`ifdef MEM_ARB_RR_EN
  // rr_ptr names the last winner, so a tie goes to the other requester
  always_comb begin
    if (&elig) grant_idx = ~rr_ptr;
    else       grant_idx = elig[1] ? OWN_DMA : OWN_CPU;
  end
`else
  logic unused_rr_ptr;
  assign unused_rr_ptr = rr_ptr;
  assign grant_idx     = elig[0] ? OWN_CPU : (elig[1] ? OWN_DMA : OWN_CPU);
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between the CPU datapath and the loader/debug DMA.
// Define MEM_ARB_RR_EN for round-robin arbitration; default build is fixed CPU priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = MEM_LAT_DEFAULT,
  parameter int CW      = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_done,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          owner_q;
  logic          cpu_gnt_q, dma_gnt_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
  logic          rr_ptr;
  logic          arb_en, accept, last_cycle;
  logic [1:0]    excl;
  logic          grant_valid, grant_idx;

  assign last_cycle = (state == ST_ACCESS) && (cnt == '0);

  // The requester finishing in DONE may not win the slot that starts right after it
  always_comb begin
    arb_en = (state == ST_IDLE) || (state == ST_DONE);
    excl   = 2'b00;
    if (state == ST_DONE) excl = (owner_q == OWN_DMA) ? 2'b10 : 2'b01;
  end

  mem_arb_pick u_pick (
    .req         ({dma_req, cpu_req}),
    .excl        (excl),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign accept = arb_en && grant_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = accept ? ST_ACCESS : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      owner_q     <= OWN_CPU;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state     <= state_nxt;
      cpu_gnt_q <= accept && (grant_idx == OWN_CPU);
      dma_gnt_q <= accept && (grant_idx == OWN_DMA);
      if (accept) begin
        owner_q   <= grant_idx;
        lat_we    <= (grant_idx == OWN_DMA) ? dma_we    : cpu_we;
        lat_addr  <= (grant_idx == OWN_DMA) ? dma_addr  : cpu_addr;
        lat_wdata <= (grant_idx == OWN_DMA) ? dma_wdata : cpu_wdata;
        cnt       <= CW'(MEM_LAT - 1);
      end else if ((state == ST_ACCESS) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (last_cycle && !lat_we) begin
        if (owner_q == OWN_DMA) dma_rdata_q <= mem_rdata;
        else                    cpu_rdata_q <= mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clock) begin
    if (reset)       rr_ptr <= OWN_DMA;
    else if (accept) rr_ptr <= grant_idx;
  end
`else
  assign rr_ptr = OWN_DMA;
`endif

  assign mem_en    = (state == ST_ACCESS);
  assign mem_we    = mem_en && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_gnt   = cpu_gnt_q;
  assign dma_gnt   = dma_gnt_q;
  assign cpu_done  = (state == ST_DONE) && (owner_q == OWN_CPU);
  assign dma_done  = (state == ST_DONE) && (owner_q == OWN_DMA);
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state != ST_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level timeline model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int CW  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, mem_wdata, mem_rdata;
  logic          cpu_gnt, cpu_done, dma_gnt, dma_done;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          mem_en, mem_we, busy, owner;

  always #5 clock = ~clock;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT), .CW(CW)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Timeline model: one active transaction granted in window g occupies
  // ACCESS windows g..g+LAT-1 and pulses done in window g+LAT.
  int            n = 0;
  int            g = 0;
  bit            has_txn = 0;
  bit            t_own, t_we;
  bit            last_win = 1'b1;
  logic [DW-1:0] m_rdata [2];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            m_owner;

  task automatic model_step();
    bit       finishing, can, win;
    bit [1:0] elig;
    if (reset) begin
      has_txn = 0; last_win = 1'b1; m_rdata[0] = '0; m_rdata[1] = '0;
      m_addr = '0; m_wdata = '0; m_owner = 1'b0; n++;
      return;
    end
    finishing = has_txn && (n == g + LAT);
    can       = !has_txn || finishing;
    if (has_txn && (n == g + LAT - 1) && !t_we) m_rdata[t_own] = mem_rdata;
    elig = {dma_req, cpu_req};
    if (finishing) begin
      elig[t_own] = 1'b0;
      has_txn = 0;
    end
    if (can && (elig != 2'b00)) begin
`ifdef MEM_ARB_RR_EN
      if (elig == 2'b11) win = ~last_win;
      else               win = elig[1];
`else
      win = ~elig[0];
`endif
      last_win = win;
      has_txn  = 1;
      g        = n + 1;
      t_own    = win;
      t_we     = win ? dma_we : cpu_we;
      m_addr   = win ? dma_addr : cpu_addr;
      m_wdata  = win ? dma_wdata : cpu_wdata;
      m_owner  = win;
    end
    n++;
  endtask

  task automatic compare();
    bit en;
    en = has_txn && (n >= g) && (n <= g + LAT - 1);
    chk("cpu_gnt",   cpu_gnt,   has_txn && (n == g) && !t_own);
    chk("dma_gnt",   dma_gnt,   has_txn && (n == g) && t_own);
    chk("cpu_done",  cpu_done,  has_txn && (n == g + LAT) && !t_own);
    chk("dma_done",  dma_done,  has_txn && (n == g + LAT) && t_own);
    chk("mem_en",    mem_en,    en);
    chk("mem_we",    mem_we,    en && t_we);
    chk("busy",      busy,      has_txn);
    chk("owner",     owner,     m_owner);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("cpu_rdata", cpu_rdata, m_rdata[0]);
    chk("dma_rdata", dma_rdata, m_rdata[1]);
  endtask

  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    compare();
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = 32'hDEADBEEF;
    step(); step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);

    // CPU read of 0x10 with memory returning 0xDEADBEEF
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    step();
    chk("t1_gnt", cpu_gnt, 1'b1);
    chk("t1_en1", mem_en, 1'b1);
    cpu_addr = 32'h99;
    step();
    chk("t1_en2", mem_en, 1'b1);
    chk("t1_addr_held", mem_addr, 32'h10);
    step();
    chk("t1_done", cpu_done, 1'b1);
    chk("t1_en_off", mem_en, 1'b0);
    cpu_req = 0;
    step();
    chk("t1_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("t1_idle", busy, 1'b0);

    // DMA write with a CPU read arriving during the DMA access
    dma_req = 1; dma_we = 1; dma_addr = 32'h4; dma_wdata = 32'h1234;
    step();
    chk("t3_dgnt", dma_gnt, 1'b1);
    chk("t3_we", mem_we, 1'b1);
    cpu_req = 1; cpu_addr = 32'h20; mem_rdata = 32'hCAFE0001;
    step(); step();
    chk("t3_ddone", dma_done, 1'b1);
    dma_req = 0;
    step();
    chk("t3_cgnt", cpu_gnt, 1'b1);
    chk("t3_cpu_we", mem_we, 1'b0);
    chk("t3_drdata", dma_rdata, 32'h0);
    step(); step();
    cpu_req = 0;
    step();
    chk("t3_crdata", cpu_rdata, 32'hCAFE0001);

    // Reset during the first ACCESS cycle
    cpu_req = 1; cpu_addr = 32'h30;
    step();
    chk("t4_access", mem_en, 1'b1);
    reset = 1'b1;
    step();
    chk("t4_busy", busy, 1'b0);
    chk("t4_en", mem_en, 1'b0);
    chk("t4_done", cpu_done, 1'b0);
    reset = 1'b0; cpu_req = 0;
    step();

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (cpu_done)     cpu_req = $urandom_range(0, 1);
      else if (cpu_req) cpu_req = ($urandom_range(0, 15) != 0);
      else              cpu_req = ($urandom_range(0, 2) == 0);
      if (dma_done)     dma_req = $urandom_range(0, 1);
      else if (dma_req) dma_req = ($urandom_range(0, 15) != 0);
      else              dma_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1) == 1) begin
        cpu_we = $urandom_range(0, 1); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if ($urandom_range(0, 1) == 1) begin
        dma_we = $urandom_range(0, 1); dma_addr = $urandom; dma_wdata = $urandom;
      end
      mem_rdata = $urandom;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
